// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data load/store) onto one single-port memory.
// Data wins unless instruction has been starved STARVE_LIMIT cycles; reads return 2 cycles after grant.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    input  logic                 InstrRead,
    output logic [WORD_SIZE-1:0] InstrIn,
    output logic                 InstrValid,
    output logic                 InstrWaitreq,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataValid,
    output logic                 DataWaitreq,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWdata,
    output logic                 MemRden,
    output logic                 MemWren,
    input  logic [WORD_SIZE-1:0] MemRdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]        starve_q, starve_d;
    logic                 tag_i_q, tag_d_q;
    logic [WORD_SIZE-1:0] instr_in_q, data_in_q;
    logic                 instr_valid_q, data_valid_q;

    logic data_req, grant_i, grant_d;

    always_comb begin
        data_req = ReadData | WriteData;
        // Grants are suppressed while Reset is high so nothing can be tagged mid-reset.
        grant_i  = InstrRead & (~data_req | (starve_q == LIMIT)) & ~Reset;
        grant_d  = data_req & ~grant_i & ~Reset;

        InstrWaitreq = InstrRead & ~grant_i;
        DataWaitreq  = data_req & ~grant_d;

        MemAddr  = '0;
        MemWdata = '0;
        MemRden  = 1'b0;
        MemWren  = 1'b0;
        if (grant_i) begin
            MemAddr = InstrAddr;
            MemRden = 1'b1;
        end else if (grant_d) begin
            MemAddr = DataAddr;
            if (WriteData) begin
                MemWdata = DataOut;
                MemWren  = 1'b1;
            end else begin
                MemRden = 1'b1;
            end
        end

        starve_d = starve_q;
        if (!InstrRead || grant_i)
            starve_d = '0;
        else if (starve_q != LIMIT)
            starve_d = starve_q + CW'(1);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            starve_q      <= '0;
            tag_i_q       <= 1'b0;
            tag_d_q       <= 1'b0;
            instr_in_q    <= '0;
            data_in_q     <= '0;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            starve_q      <= starve_d;
            tag_i_q       <= grant_i;
            tag_d_q       <= grant_d & ~WriteData;
            instr_valid_q <= tag_i_q;
            data_valid_q  <= tag_d_q;
            if (tag_i_q)
                instr_in_q <= MemRdata;
            if (tag_d_q)
                data_in_q <= MemRdata;
        end
    end

    assign InstrIn    = instr_in_q;
    assign InstrValid = instr_valid_q;
    assign DataIn     = data_in_q;
    assign DataValid  = data_valid_q;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 16, data/address width; STARVE_LIMIT, default 4, consecutive denied instruction cycles before instruction priority.
REQ-002 Clock  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 InstrAddr  in  WORD_SIZE  instruction fetch address.
REQ-005 InstrRead  in  1  instruction read request.
REQ-006 InstrIn  out  WORD_SIZE  registered instruction read data.
REQ-007 InstrValid  out  1  InstrIn updated this cycle, one-cycle pulse.
REQ-008 InstrWaitreq  out  1  instruction request pending, not accepted.
REQ-009 DataAddr  in  WORD_SIZE  data access address.
REQ-010 DataOut  in  WORD_SIZE  store data.
REQ-011 ReadData, WriteData  in  1 each  data read and data write requests.
REQ-012 DataIn  out  WORD_SIZE  registered load data.
REQ-013 DataValid  out  1  DataIn updated this cycle, one-cycle pulse.
REQ-014 DataWaitreq  out  1  data request pending, not accepted.
REQ-015 MemAddr, MemWdata  out  WORD_SIZE each  shared single-port memory address and write data.
REQ-016 MemRden, MemWren  out  1 each  memory read and write strobes.
REQ-017 MemRdata  in  WORD_SIZE  memory read data, valid the cycle after MemRden.

Function
REQ-018 A requester SHALL hold its request, address and write data stable while its Waitreq is 1; an access is accepted in the cycle its request is high and its Waitreq is 0.
REQ-019 At most one requester SHALL be granted per cycle; grant, Mem* outputs and Waitreq SHALL be combinational from the current requests and state.
REQ-020 Priority: data SHALL win over instruction unless starve_cnt == STARVE_LIMIT, in which case instruction SHALL win.
REQ-021 starve_cnt (clog2(STARVE_LIMIT+1) bits) SHALL increment when InstrRead=1 and instruction is denied, saturate at STARVE_LIMIT, and clear when instruction is granted or InstrRead=0.
REQ-022 Granted instruction: MemAddr=InstrAddr, MemRden=1, MemWren=0.
REQ-023 Granted data read: MemAddr=DataAddr, MemRden=1, MemWren=0.
REQ-024 Granted data write: MemAddr=DataAddr, MemWdata=DataOut, MemWren=1, MemRden=0; no DataValid is produced.
REQ-025 ReadData=1 and WriteData=1 together SHALL be treated as a write only.
REQ-026 With no grant: MemRden=MemWren=0, MemAddr and MemWdata=0.
REQ-027 Read return: a read granted in cycle N SHALL set a return tag (I or D) at the end of N; in N+1 MemRdata SHALL be captured into InstrIn or DataIn; the matching Valid SHALL be 1 in N+2 only.
REQ-028 Read latency from acceptance to Valid SHALL be 2 cycles; back-to-back grants SHALL sustain one access per cycle with no bubbles.
REQ-029 InstrIn and DataIn SHALL hold their last captured values until the next capture.
REQ-030 Waitreq SHALL be 0 when its requester has no active request.

Reset
REQ-031 On Reset: starve_cnt=0, return tags cleared, InstrIn=DataIn=0, InstrValid=DataValid=0; Mem* strobes 0 while Reset is high.
REQ-032 Reads accepted before or during a reset assertion SHALL never produce a Valid pulse after reset.

Verification
REQ-033 Instruction-only read, InstrAddr=0x0010, MemRdata=0xBEEF in next cycle -> InstrWaitreq=0, MemRden=1 in cycle 0; InstrValid=1 and InstrIn=0xBEEF in cycle 2.
REQ-034 Simultaneous InstrRead and ReadData (DataAddr=0x0100) -> data granted, InstrWaitreq=1, starve_cnt=1; instruction granted next cycle once data drops.
REQ-035 Continuous data reads with InstrRead held, STARVE_LIMIT=4 -> instruction denied 4 cycles, granted in cycle 5, starve_cnt=0, DataWaitreq=1 that cycle.
REQ-036 Data write DataAddr=0x0020, DataOut=0x1234, ReadData=1 too -> MemWren=1, MemRden=0, MemWdata=0x1234; no DataValid.
REQ-037 Reset asserted in cycle after a data read grant -> DataValid stays 0; DataIn=0 after reset.
REQ-038 Alternating I/D reads every cycle -> one grant per cycle; each Valid pulse paired with the correct MemRdata, in order.
